// File: rtl/uart_tx_buffered_pkg.sv
// uart_pkg: shared constants, transmitter state type and baud-rate helper
// for uart_tx_buffered and its byte FIFO.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    // Truncating divide, e.g. clks_per_bit(72_000_000, 921_600) = 78.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_buffered_fifo.sv
// byte_fifo: show-ahead synchronous FIFO; DEPTH must be a power of two so
// the pointers wrap naturally. Writes while full and reads while empty are ignored.
module byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-buffered UART transmitter, 8N1 LSB-first, valid/ready input.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit (8E1).
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 78,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          serial_tx
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    tx_state_e              state_q;
    tx_state_e              state_d;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic [BW-1:0]          bit_q;
    logic [BW-1:0]          bit_d;
    logic [DATA_BITS-1:0]   shift_q;
    logic [DATA_BITS-1:0]   shift_d;
    logic [DATA_BITS-1:0]   head;
    logic                   tx_q;
    logic                   tx_d;
    logic                   pop;
    logic                   bit_done;
    logic                   fifo_full;
    logic                   fifo_empty;

    byte_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (in_valid && in_ready),
        .wr_data (in_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign in_ready  = !fifo_full;
    assign busy      = (state_q != IDLE);
    assign serial_tx = tx_q;
    assign bit_done  = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;

        // Every non-idle state spends exactly one bit time; IDLE holds the counter at zero.
        if (state_q != IDLE) begin
            cnt_d = bit_done ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    shift_d = head;
                    pop     = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (bit_done) begin
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Line level is decoded from the next state so serial_tx comes straight from a flop.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[bit_d];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = ^shift_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- Buffered 8N1 UART transmitter: accepts bytes over a valid/ready stream, queues them in an internal FIFO, and serializes them LSB-first on serial_tx.
- Is the transmit end of the UART link. Used by the mirror design and by any block that streams bytes to the host at 921600 baud on the 72 MHz clk domain.

Parameters:
- CLKS_PER_BIT, 78, clk cycles per UART bit; minimum legal value 2 (78 = 72 MHz / 921600, truncated).
- FIFO_DEPTH, 16, byte entries in the queue; must be a power of two and at least 2.

Ports:
- clk  input  1  system clock (72 MHz).
- rst  input  1  asynchronous, active-high reset.
- in_data  input  8  byte to transmit.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  FIFO can accept a byte; equals !full.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of queued bytes, excluding the byte being shifted.
- busy  output  1  high while a frame is on the line, start bit through stop bit.
- serial_tx  output  1  UART line; idles high.

Behaviour:
- Reset (async assert, sync release): serial_tx=1, busy=0, fifo_count=0, in_ready=1; FIFO pointers cleared; FSM to IDLE.
- Reset mid-frame aborts the frame and drops all queued bytes. serial_tx goes high with no clock edge.
- Push: on a clk edge with in_valid && in_ready, in_data is written and fifo_count increments.
  - in_ready depends only on full. A push while full is not accepted, even if a pop happens in the same cycle.
- Pop: a byte leaves the FIFO on the cycle the FSM leaves IDLE.
  - A simultaneous push and pop leaves fifo_count unchanged.
- Pointers wrap modulo FIFO_DEPTH. full = (count == FIFO_DEPTH); empty = (count == 0).
- Latency: a byte pushed into an empty FIFO at edge N gives count=1 after N. The FSM pops at edge N+1, and serial_tx goes low after edge N+1 (start bit).
- Each bit lasts exactly CLKS_PER_BIT cycles. Counter width is $clog2(CLKS_PER_BIT); it counts 0..CLKS_PER_BIT-1.
- FSM states:
  - IDLE: serial_tx=1, busy=0. If !empty, load the shift register from the FIFO head, pop, go to START.
  - START: serial_tx=0 for one bit time, then go to DATA with bit_idx=0.
  - DATA: serial_tx = shift[bit_idx], LSB first. After 8 bits go to STOP (or PARITY when enabled).
  - STOP: serial_tx=1 for one bit time, then go to IDLE.
- Back-to-back frames: IDLE lasts exactly one cycle between frames when the FIFO is non-empty, so the stop bit is CLKS_PER_BIT+1 cycles. This is accepted.
- Frame length: 10*CLKS_PER_BIT cycles of busy per frame (11* with parity).
- in_data is not sampled outside a push; a changing in_data with in_valid=0 has no effect.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: PARITY state inserted between DATA and STOP; serial_tx = ^data (even parity) for one bit time. Frame is 8E1.
- Undefined: PARITY state and logic absent; frame is 8N1.

Decomposition:
- Package uart_pkg:
  - localparam DATA_BITS = 8.
  - Typedef tx_state_e (IDLE, START, DATA, PARITY, STOP).
  - Helper function clks_per_bit(clk_hz, baud) returning an int.
- Sub-module byte_fifo #(WIDTH, DEPTH):
  - Ports: clk, rst, wr_en, wr_data, rd_en, rd_data (show-ahead head), full, empty, count.
  - uart_tx_buffered instantiates byte_fifo and holds the FSM, baud counter and shift register.

Test Plan:
- Reset then idle 1000 cycles -> serial_tx=1, busy=0, in_ready=1, fifo_count=0 throughout.
- CLKS_PER_BIT=4, push 0xA5 once:
  - serial_tx falls 2 edges after the push.
  - Bits sampled at bit centres read 0,1,0,1,0,0,1,0,1,1 (start, 0xA5 LSB-first, stop).
  - busy is high for exactly 40 cycles.
- Push 16 bytes 0x00..0x0F in consecutive cycles with FIFO_DEPTH=16:
  - The first byte pops, so in_ready stays high.
  - A 17th push is accepted and an 18th is blocked (in_ready=0, fifo_count=16).
  - The line carries 0x00..0x10 in order with no gaps beyond the one-cycle IDLE.
- Push while full, on the same cycle the FSM pops -> the push is rejected and fifo_count goes 16 -> 15.
- Assert rst during DATA bit 3 of 0xFF with 5 bytes queued -> serial_tx=1 immediately, fifo_count=0; no further frames after release.
- With UART_TX_PARITY_EN, push 0x07 -> parity bit = 1 and busy is high for 11*CLKS_PER_BIT cycles. Without the macro -> 10*CLKS_PER_BIT.
